// File: rtl/im_loader.sv
// Instruction-memory loader: takes a big-endian word-count header followed by
// big-endian instruction words from a byte stream and drives the IM write port.
module im_loader #(
   parameter int                    ARCH_WIDTH   = 32,
   parameter int                    IM_WIDTH     = 32,
   parameter int                    IM_DEPTH     = 10,
   parameter logic [ARCH_WIDTH-1:0] IM_ADDR_BASE = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  im_we,
   output logic [ARCH_WIDTH-1:0] im_waddr,
   output logic [0:IM_WIDTH-1]   im_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [IM_DEPTH:0]     word_cnt
);

   localparam logic [32:0]       IM_SIZE = 33'd1 << IM_DEPTH;
   localparam logic [IM_DEPTH:0] CNT_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

   state_t                  state, state_n;
   logic [1:0]              byte_cnt, byte_cnt_n;
   logic [23:0]             hdr_buf, hdr_buf_n;
   logic [0:23]             wbuf, wbuf_n;
   logic [IM_DEPTH:0]       count, count_n;
   logic                    byte_ready_n, im_we_n, busy_n, done_n, err_n;
   logic [ARCH_WIDTH-1:0]   im_waddr_n;
   logic [0:IM_WIDTH-1]     im_wdata_n;
   logic [IM_DEPTH:0]       word_cnt_n;

   logic                    xfer;
   logic [31:0]             hdr_word;
   logic [0:IM_WIDTH-1]     word;
   logic [IM_DEPTH:0]       word_cnt_inc;
   logic [ARCH_WIDTH-1:0]   waddr_calc;

   assign xfer         = byte_valid & byte_ready;
   assign hdr_word     = {hdr_buf, byte_in};
   assign word         = {wbuf, byte_in};
   assign word_cnt_inc = word_cnt + CNT_ONE;
   // word_cnt equals the index k of the word being assembled
   assign waddr_calc   = IM_ADDR_BASE + (ARCH_WIDTH'(word_cnt[IM_DEPTH-1:0]) << 2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_cnt   <= '0;
         hdr_buf    <= '0;
         wbuf       <= '0;
         count      <= '0;
         byte_ready <= 1'b0;
         im_we      <= 1'b0;
         im_waddr   <= '0;
         im_wdata   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_cnt   <= '0;
      end else begin
         state      <= state_n;
         byte_cnt   <= byte_cnt_n;
         hdr_buf    <= hdr_buf_n;
         wbuf       <= wbuf_n;
         count      <= count_n;
         byte_ready <= byte_ready_n;
         im_we      <= im_we_n;
         im_waddr   <= im_waddr_n;
         im_wdata   <= im_wdata_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
         word_cnt   <= word_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      byte_cnt_n = byte_cnt;
      hdr_buf_n  = hdr_buf;
      wbuf_n     = wbuf;
      count_n    = count;
      im_we_n    = 1'b0;
      im_waddr_n = im_waddr;
      im_wdata_n = im_wdata;
      done_n     = done;
      err_n      = err;
      word_cnt_n = word_cnt;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_n    = S_HDR;
               byte_cnt_n = '0;
               done_n     = 1'b0;
               err_n      = 1'b0;
               word_cnt_n = '0;
            end else if (state == S_DONE) begin
               // done trails entry into DONE by a cycle so the last write lands first
               done_n = 1'b1;
            end
         end
         S_HDR: begin
            if (xfer) begin
               byte_cnt_n = byte_cnt + 2'd1;
               hdr_buf_n  = {hdr_buf[15:0], byte_in};
               if (byte_cnt == 2'd3) begin
                  if (hdr_word == 32'd0) begin
                     state_n = S_DONE;
                  end else if ({1'b0, hdr_word} > IM_SIZE) begin
                     state_n = S_ERR;
                     err_n   = 1'b1;
                  end else begin
                     state_n = S_DATA;
                     count_n = hdr_word[IM_DEPTH:0];
                  end
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               byte_cnt_n = byte_cnt + 2'd1;
               wbuf_n     = {wbuf[8:23], byte_in};
               if (byte_cnt == 2'd3) begin
                  im_we_n    = 1'b1;
                  im_wdata_n = word;
                  im_waddr_n = waddr_calc;
                  word_cnt_n = word_cnt_inc;
                  if (word_cnt_inc == count) begin
                     state_n = S_DONE;
                  end
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      byte_ready_n = (state_n == S_HDR) || (state_n == S_DATA);
      busy_n       = byte_ready_n;
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: writes are predicted into a scoreboard queue
// as words are streamed and checked against the IM write port as they appear.
module tb_im_loader;

   localparam logic [31:0] BASE = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        im_we;
   logic [31:0] im_waddr;
   logic [0:31] im_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [10:0] word_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_hs = 0;
   logic [63:0] sb[$];
   int          k_next = 0;

   im_loader #(
      .ARCH_WIDTH(32),
      .IM_WIDTH(32),
      .IM_DEPTH(10),
      .IM_ADDR_BASE(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .im_we(im_we),
      .im_waddr(im_waddr),
      .im_wdata(im_wdata),
      .busy(busy),
      .done(done),
      .err(err),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (byte_valid && byte_ready) last_hs <= cyc;
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         logic [63:0] e;
         chk("we_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("we_addr", 64'(im_waddr), 64'(e[63:32]));
            chk("we_data", 64'(im_wdata), 64'(e[31:0]));
            chk("we_latency", 64'(cyc), 64'(last_hs + 1));
         end
      end
   end

   // All tasks are entered and left on a falling edge.
   task automatic send_byte(input logic [7:0] b, input int maxgap);
      int gap;
      int t;
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int i = 0; i < gap; i++) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_in    = b;
      t = 0;
      while (byte_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (byte_ready !== 1'b1) begin
         chk("byte_ready_timeout", 64'(byte_ready), 64'd1);
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] n, input int maxgap);
      for (int i = 3; i >= 0; i--) send_byte(n[8*i +: 8], maxgap);
   endtask

   // Predicts the write for index k_next, then streams the word.
   task automatic send_word(input logic [31:0] w, input int maxgap);
      logic [31:0] a;
      a = BASE + 32'(k_next) * 32'd4;
      sb.push_back({a, w});
      k_next++;
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], maxgap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      chk({tag, "_im_we"}, 64'(im_we), 64'd0);
      chk({tag, "_im_waddr"}, 64'(im_waddr), 64'd0);
      chk({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
   endtask

   task automatic normal_load(input int maxgap);
      k_next = 0;
      pulse_start();
      chk("load_busy", 64'(busy), 64'd1);
      send_hdr(32'd2, maxgap);
      send_word(32'h7C08_02A6, maxgap);
      send_word(32'h3821_0010, maxgap);
      chk("last_we_before_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("load_done", 64'(done), 64'd1);
      chk("load_word_cnt", 64'(word_cnt), 64'd2);
      chk("load_busy_end", 64'(busy), 64'd0);
      chk("load_sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      // reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("reset");
      pulse_start();
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_byte_ready", 64'(byte_ready), 64'd1);

      // normal load from this already-started state
      k_next = 0;
      send_hdr(32'd2, 0);
      send_word(32'h7C08_02A6, 0);
      send_word(32'h3821_0010, 0);
      chk("n_last_we_before_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("n_done", 64'(done), 64'd1);
      chk("n_word_cnt", 64'(word_cnt), 64'd2);
      chk("n_busy", 64'(busy), 64'd0);
      chk("n_byte_ready", 64'(byte_ready), 64'd0);

      // restart clears done/word_cnt; zero-length header
      pulse_start();
      chk("z_done_cleared", 64'(done), 64'd0);
      chk("z_word_cnt_cleared", 64'(word_cnt), 64'd0);
      send_hdr(32'd0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("z_done", 64'(done), 64'd1);
      chk("z_word_cnt", 64'(word_cnt), 64'd0);
      chk("z_err", 64'(err), 64'd0);

      // oversize header
      pulse_start();
      send_hdr(32'd1025, 0);
      @(negedge clk);
      chk("o_err", 64'(err), 64'd1);
      chk("o_byte_ready", 64'(byte_ready), 64'd0);
      chk("o_busy", 64'(busy), 64'd0);
      chk("o_done", 64'(done), 64'd0);
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      chk("o_ignores_bytes", 64'(byte_ready), 64'd0);
      chk("o_err_held", 64'(err), 64'd1);

      // exactly full memory
      k_next = 0;
      pulse_start();
      chk("f_err_cleared", 64'(err), 64'd0);
      send_hdr(32'd1024, 0);
      for (int i = 0; i < 1024; i++) send_word(32'hA500_0000 ^ (32'(i) * 32'h0001_0203), 0);
      chk("f_last_addr", 64'(im_waddr), 64'(BASE + 32'h0000_0FFC));
      @(negedge clk);
      chk("f_done", 64'(done), 64'd1);
      chk("f_word_cnt", 64'(word_cnt), 64'd1024);
      chk("f_err", 64'(err), 64'd0);

      // backpressure gaps, with a start pulse mid-load that must be ignored
      k_next = 0;
      pulse_start();
      send_hdr(32'd2, 3);
      send_word(32'h7C08_02A6, 3);
      pulse_start();
      chk("bp_start_ignored_busy", 64'(busy), 64'd1);
      chk("bp_start_ignored_cnt", 64'(word_cnt), 64'd1);
      send_word(32'h3821_0010, 3);
      @(negedge clk);
      chk("bp_done", 64'(done), 64'd1);
      chk("bp_word_cnt", 64'(word_cnt), 64'd2);
      chk("bp_sb_drained", 64'(sb.size()), 64'd0);

      // reset part-way through word 1: no write for it
      k_next = 0;
      pulse_start();
      send_hdr(32'd2, 0);
      send_word(32'h1122_3344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("midrst");
      repeat (3) @(negedge clk);
      chk("midrst_no_write", 64'(im_we), 64'd0);
      chk("midrst_sb_drained", 64'(sb.size()), 64'd0);

      // fresh load after reset, with gaps
      normal_load(2);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
